// File: rtl/types_gpio_pkg.sv
// rtl/types_gpio_pkg.sv - shared FSM state type and default constants for the GPIO debouncer
package types_gpio_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } deb_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int          CNT_WIDTH_DEFAULT       = 16;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one channel: two-flop synchronizer, stability counter FSM, edge pulses
module debounce_bit
  import types_gpio_pkg::*;
#(
  parameter int          cnt_width       = CNT_WIDTH_DEFAULT,
  parameter int unsigned debounce_cycles = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic        reset_value     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_gpio,
  input  logic i_bypass,
  output logic o_gpio,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [cnt_width-1:0] cnt_limit = cnt_width'(debounce_cycles);
  localparam logic [cnt_width-1:0] cnt_max   = {cnt_width{1'b1}};

  logic [1:0]           sync_q;
  logic                 sync;
  deb_state_e           state_q, state_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic                 stable_q, stable_d;
  logic                 rise_q, fall_q;

  assign sync = sync_q[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q   <= {2{reset_value}};
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      stable_q <= reset_value;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], i_gpio};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
    end
  end

  // Bypass overrides everything: any count in progress is dropped and stable tracks sync.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (i_bypass) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      stable_d = sync;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sync != stable_q) begin
            state_d = ST_COUNT;
            cnt_d   = {{(cnt_width-1){1'b0}}, 1'b1};
          end
        end
        ST_COUNT: begin
          if (sync == stable_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == cnt_limit) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            stable_d = sync;
          end else if (cnt_q != cnt_max) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_gpio = stable_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - multi-channel GPIO debouncer with per-bit bypass and edge pulses
module gpio_debounce
  import types_gpio_pkg::*;
#(
  parameter int               width           = 12,
  parameter int               cnt_width       = CNT_WIDTH_DEFAULT,
  parameter int unsigned      debounce_cycles = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [width-1:0] reset_value     = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [width-1:0] i_gpio,
  input  logic [width-1:0] i_bypass,
  output logic [width-1:0] o_gpio,
  output logic [width-1:0] o_rise,
  output logic [width-1:0] o_fall,
  output logic             o_changed
);

  for (genvar g = 0; g < width; g++) begin : g_bit
    debounce_bit #(
      .cnt_width       (cnt_width),
      .debounce_cycles (debounce_cycles),
      .reset_value     (reset_value[g])
    ) u_bit (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_gpio   (i_gpio[g]),
      .i_bypass (i_bypass[g]),
      .o_gpio   (o_gpio[g]),
      .o_rise   (o_rise[g]),
      .o_fall   (o_fall[g])
    );
  end

  assign o_changed = |(o_rise | o_fall);

endmodule

// File: tb/tb_gpio_debounce.sv
// tb/tb_gpio_debounce.sv - randomized and directed self-checking bench for gpio_debounce
module tb_gpio_debounce;

  localparam int W = 12;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         i_rst;
  logic [W-1:0] i_gpio, i_bypass;
  logic [W-1:0] o_gpio, o_rise, o_fall;
  logic         o_changed;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference state: two sampled-input stages, accepted level, run length of disagreement
  logic [W-1:0] m_d1, m_d2, m_stable, m_rise, m_fall;
  int           m_run [W];

  gpio_debounce #(
    .width           (W),
    .cnt_width       (16),
    .debounce_cycles (N),
    .reset_value     ('0)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_gpio    (i_gpio),
    .i_bypass  (i_bypass),
    .o_gpio    (o_gpio),
    .o_rise    (o_rise),
    .o_fall    (o_fall),
    .o_changed (o_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // A level is accepted once the synchronized value has disagreed with the accepted
  // level for N+1 consecutive cycles; bypass accepts the synchronized value directly.
  task automatic model_edge();
    logic [W-1:0] ns;
    if (i_rst) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      return;
    end
    ns = m_stable;
    for (int i = 0; i < W; i++) begin
      if (i_bypass[i]) begin
        ns[i] = m_d2[i];
        m_run[i] = 0;
      end else if (m_d2[i] != m_stable[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == N + 1) begin
          ns[i] = m_d2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_rise   = ns & ~m_stable;
    m_fall   = ~ns & m_stable;
    m_stable = ns;
    m_d2     = m_d1;
    m_d1     = i_gpio;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check("o_gpio", 32'(o_gpio), 32'(m_stable));
    check("o_rise", 32'(o_rise), 32'(m_rise));
    check("o_fall", 32'(o_fall), 32'(m_fall));
    check("o_changed", 32'(o_changed), 32'(|(m_rise | m_fall)));
  endtask

  initial begin
    int pulses, first, hit;
    logic [W-1:0] mask;
    bit noisy;

    i_rst = 1'b1;
    i_gpio = '0;
    i_bypass = '0;
    step();
    step();
    check("reset_gpio", 32'(o_gpio), 32'h0);
    i_rst = 1'b0;
    cyc = 0;

    // clean step on bit 0
    for (int k = 1; k <= 20; k++) begin
      if (k == 10) i_gpio[0] = 1'b1;
      step();
      if (cyc == 15) check("b0_before", 32'(o_gpio[0]), 32'h0);
      if (cyc == 16) begin
        check("b0_accept", 32'(o_gpio[0]), 32'h1);
        check("b0_rise", 32'(o_rise[0]), 32'h1);
        check("b0_changed", 32'(o_changed), 32'h1);
      end
      if (cyc == 17) check("b0_rise_once", 32'(o_rise[0]), 32'h0);
    end

    // glitch on bit 3 shorter than the filter
    for (int k = 0; k < 12; k++) begin
      i_gpio[3] = (k < 3);
      step();
      check("b3_glitch", 32'({o_gpio[3], o_rise[3], o_fall[3]}), 32'h0);
    end

    // bypass on bit 5
    i_bypass[5] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 12 && k % 2 == 0) i_gpio[5] = ~i_gpio[5];
      step();
      pulses += int'(o_rise[5]) + int'(o_fall[5]);
    end
    check("b5_pulses", 32'(pulses), 32'd6);
    check("b5_final", 32'(o_gpio[5]), 32'h0);
    i_bypass[5] = 1'b0;

    // reset mid-count on bit 7
    i_gpio[7] = 1'b1;
    for (int k = 0; k < 5; k++) step();
    i_rst = 1'b1;
    #1;
    check("rst_async_gpio", 32'(o_gpio), 32'h0);
    check("rst_async_rise", 32'(o_rise), 32'h0);
    step();
    i_rst = 1'b0;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 0) check("rst_exit_pulse", 32'(o_rise | o_fall), 32'h0);
      if (first < 0 && o_gpio[7]) first = k;
    end
    check("b7_accept_at", 32'(first), 32'd6);

    // all bits together
    i_gpio = '0;
    for (int k = 0; k < 12; k++) step();
    i_gpio = '1;
    hit = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (hit < 0 && o_rise != 0) begin
        hit = k;
        check("all_rise", 32'(o_rise), 32'hFFF);
      end
    end
    check("all_rise_at", 32'(hit), 32'd6);
    i_gpio = '0;
    hit = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (hit < 0 && o_fall != 0) begin
        hit = k;
        check("all_fall", 32'(o_fall), 32'hFFF);
      end
    end
    check("all_fall_at", 32'(hit), 32'd6);

    // randomized traffic: alternating quiet and noisy phases, bypass churn, rare resets
    noisy = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) noisy = ($urandom_range(0, 1) == 1);
      if (k % 16 == 0) i_bypass = W'($urandom & $urandom & $urandom);
      i_rst = ($urandom_range(0, 399) == 0);
      if (noisy) mask = W'($urandom & $urandom);
      else       mask = W'($urandom & $urandom & $urandom & $urandom & $urandom);
      i_gpio = i_gpio ^ mask;
      step();
    end
    i_rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
